ode_packet_transmitter: RTL and testbench

//  Host-side transmitter for the IO load protocol: streams solver input words from a source RAM onto the 32-bit CPU_Bus.
//  The IO module's receiver/decoder sits at the other end and writes the words into solver memory.

---
 rtl/ode_packet_transmitter_if.sv | 28 ++
 rtl/ode_packet_transmitter.sv | 174 +++++++++++++++++
 tb/tb_ode_packet_transmitter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ode_packet_transmitter_if.sv
// CPU_Bus side of the IO load protocol: beats and interrupt towards the IO module,
// per-packet acknowledge and completion coming back from its receiver.
interface ode_packet_transmitter_if;
    logic [31:0] Bus_Data;
    logic        Bus_Drive;
    logic        INT;
    logic        Load_Process;
    logic        Packet_Ack;
    logic        Done_Loading;

    modport master (
        output Bus_Data,
        output Bus_Drive,
        output INT,
        output Load_Process,
        input  Packet_Ack,
        input  Done_Loading
    );

    modport slave (
        input  Bus_Data,
        input  Bus_Drive,
        input  INT,
        input  Load_Process,
        output Packet_Ack,
        output Done_Loading
    );
endinterface

// File: rtl/ode_packet_transmitter.sv
// Host-side IO load transmitter: interrupt, header beat, then each 64-bit source word as two
// 32-bit CPU_Bus beats, pausing for a receiver acknowledge after every PACKET_WORDS words.
module ode_packet_transmitter #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64,
    parameter int PACKET_WORDS  = 16,
    parameter int ACK_TIMEOUT   = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start,
    input  logic [ADDRESS_WIDTH-1:0] Word_Count,
    input  logic [DATA_WIDTH-1:0]    Src_Data,
    output logic [ADDRESS_WIDTH-1:0] Src_Address,
    output logic                     Src_RD_Enable,
    output logic                     Busy,
    output logic                     Done_Sending,
    output logic                     Error,
    ode_packet_transmitter_if.master bus
);

    localparam int PKT_W = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        IRQ,
        HEADER,
        FETCH,
        SEND_LO,
        SEND_HI,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0] sent_q, sent_d;
    logic [ADDRESS_WIDTH-1:0] wc_q, wc_d;
    logic [PKT_W-1:0]         pkt_q, pkt_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [31:0]              hold_q, hold_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     last_in_pkt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sent_q  <= '0;
            wc_q    <= '0;
            pkt_q   <= '0;
            tmo_q   <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sent_q  <= sent_d;
            wc_q    <= wc_d;
            pkt_q   <= pkt_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign last_in_pkt = (pkt_q == PKT_W'(PACKET_WORDS - 1));

    // The timeout counter defaults to clear, so it only accumulates while parked in a wait state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sent_d  = sent_q;
        wc_d    = wc_q;
        pkt_d   = pkt_q;
        tmo_d   = '0;
        hold_d  = hold_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Word_Count != '0) begin
                        wc_d    = Word_Count;
                        state_d = IRQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            IRQ: begin
                addr_d  = '0;
                sent_d  = '0;
                pkt_d   = '0;
                state_d = HEADER;
            end
            HEADER: state_d = FETCH;
            FETCH:  state_d = SEND_LO;
            SEND_LO: begin
                hold_d  = Src_Data[63:32];
                state_d = SEND_HI;
            end
            SEND_HI: begin
                addr_d = addr_q + 1'b1;
                sent_d = sent_q + 1'b1;
                pkt_d  = last_in_pkt ? '0 : pkt_q + 1'b1;
                // A final word landing on a packet boundary skips the acknowledge wait.
                if (sent_d == wc_q) begin
                    state_d = WAIT_DONE;
                end else if (last_in_pkt) begin
                    state_d = WAIT_ACK;
                end else begin
                    state_d = FETCH;
                end
            end
            WAIT_ACK: begin
                if (bus.Packet_Ack) begin
                    state_d = FETCH;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.Done_Loading) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from the state register so reset drops the bus without waiting for a clock.
    always_comb begin
        Busy             = (state_q != IDLE);
        Src_RD_Enable    = (state_q == FETCH);
        Src_Address      = addr_q;
        Done_Sending     = done_q;
        Error            = error_q;
        bus.INT          = (state_q == IRQ);
        bus.Load_Process = (state_q == IRQ);
        bus.Bus_Drive    = 1'b0;
        bus.Bus_Data     = '0;
        case (state_q)
            HEADER: begin
                bus.Bus_Drive = 1'b1;
                bus.Bus_Data  = 32'(wc_q);
            end
            SEND_LO: begin
                bus.Bus_Drive = 1'b1;
                bus.Bus_Data  = Src_Data[31:0];
            end
            SEND_HI: begin
                bus.Bus_Drive = 1'b1;
                bus.Bus_Data  = hold_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ode_packet_transmitter.sv
// Self-checking bench: a cycle timeline built from the protocol rules drives inputs and
// predicts every output cycle; a few hand-derived literals pin both model and DUT.
module tb_ode_packet_transmitter;

    localparam int AW  = 6;
    localparam int PW  = 4;
    localparam int TMO = 16;

    typedef struct packed {
        logic          busy;
        logic          drive;
        logic          intr;
        logic          lp;
        logic          rd;
        logic          done;
        logic          err;
        logic [31:0]   data;
        logic [AW-1:0] addr;
    } obs_t;

    typedef struct packed {
        logic          start;
        logic [AW-1:0] wc;
        logic          ack;
        logic          dl;
    } stim_t;

    logic          CLK;
    logic          RST;
    logic          Start;
    logic [AW-1:0] Word_Count;
    logic [63:0]   Src_Data;
    logic [AW-1:0] Src_Address;
    logic          Src_RD_Enable;
    logic          Busy;
    logic          Done_Sending;
    logic          Error;

    ode_packet_transmitter_if bus_if ();

    ode_packet_transmitter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (64),
        .PACKET_WORDS  (PW),
        .ACK_TIMEOUT   (TMO)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .Start         (Start),
        .Word_Count    (Word_Count),
        .Src_Data      (Src_Data),
        .Src_Address   (Src_Address),
        .Src_RD_Enable (Src_RD_Enable),
        .Busy          (Busy),
        .Done_Sending  (Done_Sending),
        .Error         (Error),
        .bus           (bus_if)
    );

    logic [63:0] ram [0:(1<<AW)-1];
    obs_t        exp_q[$];
    stim_t       stim_q[$];
    logic [31:0] cap_beats[$];
    int          total;
    int          bad;
    int          cyc;
    int          last_drive_cyc;
    int          err_cyc;
    int          waits;
    logic        prev_drive;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Source RAM with one cycle of read latency.
    always @(posedge CLK) begin
        if (Src_RD_Enable) Src_Data <= ram[Src_Address];
    end

    function automatic obs_t observe();
        obs_t o;
        o       = '0;
        o.busy  = Busy;
        o.drive = bus_if.Bus_Drive;
        o.intr  = bus_if.INT;
        o.lp    = bus_if.Load_Process;
        o.rd    = Src_RD_Enable;
        o.done  = Done_Sending;
        o.err   = Error;
        if (bus_if.Bus_Drive) o.data = bus_if.Bus_Data;
        if (Src_RD_Enable) o.addr = Src_Address;
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the timeline, plus DUT-side capture for the literal checks.
    always @(negedge CLK) begin : compare
        obs_t o;
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL cycle_%0d: got busy=%b drive=%b int=%b lp=%b rd=%b done=%b err=%b data=%h addr=%0d, expected busy=%b drive=%b int=%b lp=%b rd=%b done=%b err=%b data=%h addr=%0d",
                         cyc, o.busy, o.drive, o.intr, o.lp, o.rd, o.done, o.err, o.data, o.addr,
                         e.busy, e.drive, e.intr, e.lp, e.rd, e.done, e.err, e.data, e.addr);
            end
            if (o.drive) begin
                cap_beats.push_back(o.data);
                last_drive_cyc = cyc;
            end
            if (prev_drive && !o.drive && !o.rd && o.busy) waits++;
            if (o.err) err_cyc = cyc;
            prev_drive = o.drive;
            cyc++;
        end
    end

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 15);
        if (r == 15) return TMO + 4;
        if (r == 14) return TMO - 1;
        return r % 8;
    endfunction

    function automatic stim_t noise(input bit noisy);
        stim_t s;
        s = '0;
        if (noisy) begin
            s.start = ($urandom_range(0, 3) == 0);
            s.wc    = AW'($urandom);
            s.ack   = ($urandom_range(0, 3) == 0);
            s.dl    = ($urandom_range(0, 3) == 0);
        end
        return s;
    endfunction

    function automatic void push(input obs_t e, input stim_t s);
        exp_q.push_back(e);
        stim_q.push_back(s);
    endfunction

    // Timeline of one transfer: Start cycle, INT, header, three cycles per word, waits, closing pulse.
    task automatic build_transfer(input int n, input int ack_fixed, input int done_dly, input bit noisy);
        obs_t  e;
        stim_t s;
        int    d;
        bit    aborted;
        aborted = 1'b0;
        e = '0;
        s = '0;
        s.start = 1'b1;
        s.wc    = AW'(n);
        push(e, s);
        if (n == 0) begin
            e = '0;
            e.done = 1'b1;
            push(e, '0);
        end else begin
            e = '0; e.busy = 1'b1; e.intr = 1'b1; e.lp = 1'b1;
            push(e, noise(noisy));
            e = '0; e.busy = 1'b1; e.drive = 1'b1; e.data = 32'(n);
            push(e, noise(noisy));
            for (int k = 1; k <= n && !aborted; k++) begin
                e = '0; e.busy = 1'b1; e.rd = 1'b1; e.addr = AW'(k - 1);
                push(e, noise(noisy));
                e = '0; e.busy = 1'b1; e.drive = 1'b1; e.data = ram[k-1][31:0];
                push(e, noise(noisy));
                e.data = ram[k-1][63:32];
                push(e, noise(noisy));
                if (k == n || k % PW == 0) begin
                    d = (k == n) ? done_dly : ((ack_fixed >= 0) ? ack_fixed : pick_delay());
                    for (int j = 0; j <= d && j < TMO; j++) begin
                        e = '0; e.busy = 1'b1;
                        s = noise(noisy);
                        if (k == n) s.dl = (j == d);
                        else        s.ack = (j == d);
                        push(e, s);
                    end
                    e = '0;
                    if (d >= TMO) begin
                        e.err   = 1'b1;
                        aborted = 1'b1;
                        push(e, '0);
                    end else if (k == n) begin
                        e.done = 1'b1;
                        push(e, '0);
                    end
                end
            end
        end
        push('0, '0);
    endtask

    task automatic applyStimulus(input int n, input int ack_fixed, input int done_dly,
                                 input bit noisy, input int exp_len);
        stim_t s;
        cap_beats.delete();
        cyc            = 0;
        waits          = 0;
        prev_drive     = 1'b0;
        err_cyc        = -1;
        last_drive_cyc = -1;
        @(posedge CLK);
        #1;
        build_transfer(n, ack_fixed, done_dly, noisy);
        if (exp_len >= 0) checkOutput($sformatf("model_len_n%0d", n), stim_q.size(), exp_len);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            Start               = s.start;
            Word_Count          = s.wc;
            bus_if.Packet_Ack   = s.ack;
            bus_if.Done_Loading = s.dl;
            @(posedge CLK);
            #1;
        end
        Start               = 1'b0;
        Word_Count          = '0;
        bus_if.Packet_Ack   = 1'b0;
        bus_if.Done_Loading = 1'b0;
    endtask

    task automatic fill_ram();
        for (int a = 0; a < (1 << AW); a++) ram[a] = {$urandom, $urandom};
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        total               = 0;
        bad                 = 0;
        RST                 = 1'b0;
        Start               = 1'b0;
        Word_Count          = '0;
        Src_Data            = '0;
        bus_if.Packet_Ack   = 1'b0;
        bus_if.Done_Loading = 1'b0;
        fill_ram();
        #2;
        checkOutput("reset_outputs", observe(), '0);
        checkOutput("reset_bus_data", bus_if.Bus_Data, '0);
        checkOutput("reset_address", Src_Address, '0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // Single word with known contents.
        ram[0] = 64'h1111_2222_3333_4444;
        applyStimulus(1, 0, 2, 1'b0, 11);
        checkOutput("t1_beat_count", cap_beats.size(), 3);
        checkOutput("t1_header", cap_beats[0], 32'h1);
        checkOutput("t1_low_half", cap_beats[1], 32'h3333_4444);
        checkOutput("t1_high_half", cap_beats[2], 32'h1111_2222);

        fill_ram();
        applyStimulus(10, 5, 1, 1'b0, 49);
        checkOutput("t2_beat_count", cap_beats.size(), 21);
        checkOutput("t2_wait_entries", waits, 3);

        applyStimulus(8, 2, 0, 1'b0, -1);
        checkOutput("t3_beat_count", cap_beats.size(), 17);
        checkOutput("t3_wait_entries", waits, 2);

        applyStimulus(6, TMO + 10, 0, 1'b0, 33);
        checkOutput("t4_beat_count", cap_beats.size(), 9);
        checkOutput("t4_error_delay", err_cyc - (last_drive_cyc + 1), 16);

        fill_ram();
        applyStimulus(9, 3, 2, 1'b1, -1);
        checkOutput("t5_wait_entries", waits, 3);
        checkOutput("t5_beat_count", cap_beats.size(), 19);

        applyStimulus(5, TMO - 1, 3, 1'b1, -1);
        applyStimulus((1 << AW) - 1, 0, 0, 1'b1, -1);
        checkOutput("max_beat_count", cap_beats.size(), 1 + 2 * ((1 << AW) - 1));

        for (int r = 0; r < 14; r++) begin
            fill_ram();
            case ($urandom_range(0, 5))
                0:       n = 0;
                1:       n = (1 << AW) - 1;
                default: n = $urandom_range(1, 20);
            endcase
            applyStimulus(n, -1, pick_delay(), 1'b1, -1);
        end

        // Reset in the middle of the third word's high beat.
        fill_ram();
        @(posedge CLK);
        #1;
        Start      = 1'b1;
        Word_Count = AW'(5);
        @(posedge CLK);
        #1;
        Start      = 1'b0;
        Word_Count = '0;
        repeat (10) @(posedge CLK);
        #1;
        checkOutput("pre_reset_hi_beat", {bus_if.Bus_Drive, bus_if.Bus_Data}, {1'b1, ram[2][63:32]});
        RST = 1'b0;
        #1;
        checkOutput("reset_mid_outputs", observe(), '0);
        checkOutput("reset_mid_bus_data", bus_if.Bus_Data, '0);
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_hold_outputs", observe(), '0);
        RST = 1'b1;
        applyStimulus(0, 0, 0, 1'b0, 3);

        checkOutput("timeline_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
